// File: rtl/modulation_swapchain.sv
// Modulation swapchain: picks which per-segment timer index drives the
// modulation memory read address, handling segment switches and loop stops.
module modulation_swapchain #(
    parameter int IDX_W = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [63:0]      SYS_TIME,
    input  logic             UPDATE_SETTINGS,
    input  logic             REQ_SEGMENT,
    input  logic [7:0]       TRANSITION_MODE,
    input  logic [63:0]      TRANSITION_VALUE,
    input  logic [15:0]      REP,
    input  logic [IDX_W-1:0] CYCLE_0,
    input  logic [IDX_W-1:0] CYCLE_1,
    input  logic [IDX_W-1:0] IDX_0_IN,
    input  logic [IDX_W-1:0] IDX_1_IN,
    output logic             SEGMENT,
    output logic [IDX_W-1:0] IDX_OUT,
    output logic             STOP,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        RUN,
        WAIT_IDX,
        WAIT_TIME,
        STOPPED
    } state_t;

    localparam logic [7:0]  MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0]  MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0]  MODE_IMMEDIATE = 8'hFF;
    localparam logic [15:0] REP_INF        = 16'hFFFF;

    state_t           state, state_n;
    logic             seg, seg_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             stop, stop_n;
    logic             busy, busy_n;
    logic [15:0]      rep_act, rep_n;
    logic [15:0]      loop_cnt, loop_n;
    logic [IDX_W-1:0] prev_0, prev_1;
    logic             pend_seg, pend_seg_n;
    logic [63:0]      pend_val, pend_val_n;
    logic [15:0]      pend_rep, pend_rep_n;

    logic             wrap_0, wrap_1, wrap_act, wrap_req;
    logic [IDX_W-1:0] idx_act, cyc_act;
    logic             commit;
    logic             c_seg;
    logic [15:0]      c_rep;

    assign wrap_0   = IDX_0_IN < prev_0;
    assign wrap_1   = IDX_1_IN < prev_1;
    assign wrap_act = seg ? wrap_1 : wrap_0;
    assign wrap_req = pend_seg ? wrap_1 : wrap_0;
    assign idx_act  = seg ? IDX_1_IN : IDX_0_IN;
    assign cyc_act  = seg ? CYCLE_1 : CYCLE_0;

    // State, output and pending-request registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            seg      <= 1'b0;
            idx      <= '0;
            stop     <= 1'b0;
            busy     <= 1'b0;
            rep_act  <= REP_INF;
            loop_cnt <= '0;
            prev_0   <= '0;
            prev_1   <= '0;
            pend_seg <= 1'b0;
            pend_val <= '0;
            pend_rep <= REP_INF;
        end else begin
            state    <= state_n;
            seg      <= seg_n;
            idx      <= idx_n;
            stop     <= stop_n;
            busy     <= busy_n;
            rep_act  <= rep_n;
            loop_cnt <= loop_n;
            prev_0   <= IDX_0_IN;
            prev_1   <= IDX_1_IN;
            pend_seg <= pend_seg_n;
            pend_val <= pend_val_n;
            pend_rep <= pend_rep_n;
        end
    end

    // Playback step, request handling and commit selection
    always_comb begin
        state_n    = state;
        seg_n      = seg;
        idx_n      = idx;
        stop_n     = stop;
        busy_n     = busy;
        rep_n      = rep_act;
        loop_n     = loop_cnt;
        pend_seg_n = pend_seg;
        pend_val_n = pend_val;
        pend_rep_n = pend_rep;
        commit     = 1'b0;
        c_seg      = pend_seg;
        c_rep      = pend_rep;

        // Active segment keeps looping/stopping even while a switch waits
        if (stop) begin
            idx_n = cyc_act;
        end else begin
            idx_n = idx_act;
            if (rep_act != REP_INF && wrap_act) begin
                if (loop_cnt == rep_act) begin
                    stop_n = 1'b1;
                    idx_n  = cyc_act;
                end else begin
                    loop_n = loop_cnt + 16'd1;
                end
            end
        end
        if (state == RUN || state == STOPPED)
            state_n = stop_n ? STOPPED : RUN;

        if (UPDATE_SETTINGS) begin
            if (REQ_SEGMENT == seg) begin
                pend_seg_n = REQ_SEGMENT;
                pend_val_n = TRANSITION_VALUE;
                pend_rep_n = REP;
                rep_n      = REP;
                loop_n     = '0;
                stop_n     = 1'b0;
                busy_n     = 1'b0;
                idx_n      = idx_act;
                state_n    = RUN;
            end else begin
                case (TRANSITION_MODE)
                    MODE_IMMEDIATE: begin
                        pend_seg_n = REQ_SEGMENT;
                        pend_val_n = TRANSITION_VALUE;
                        pend_rep_n = REP;
                        commit     = 1'b1;
                        c_seg      = REQ_SEGMENT;
                        c_rep      = REP;
                    end
                    MODE_SYNC_IDX: begin
                        pend_seg_n = REQ_SEGMENT;
                        pend_val_n = TRANSITION_VALUE;
                        pend_rep_n = REP;
                        busy_n     = 1'b1;
                        state_n    = WAIT_IDX;
                    end
                    MODE_SYS_TIME: begin
                        pend_seg_n = REQ_SEGMENT;
                        pend_val_n = TRANSITION_VALUE;
                        pend_rep_n = REP;
                        busy_n     = 1'b1;
                        state_n    = WAIT_TIME;
                    end
                    default: ;
                endcase
            end
        end else if (state == WAIT_IDX && wrap_req) begin
            commit = 1'b1;
        end else if (state == WAIT_TIME && SYS_TIME >= pend_val) begin
            commit = 1'b1;
        end

        if (commit) begin
            seg_n   = c_seg;
            idx_n   = c_seg ? IDX_1_IN : IDX_0_IN;
            rep_n   = c_rep;
            loop_n  = '0;
            stop_n  = 1'b0;
            busy_n  = 1'b0;
            state_n = RUN;
        end
    end

    assign SEGMENT = seg;
    assign IDX_OUT = idx;
    assign STOP    = stop;
    assign BUSY    = busy;

endmodule

// File: tb/tb_modulation_swapchain.sv
// Directed bench for modulation_swapchain: switching modes, loop stop,
// request replacement and asynchronous reset.
module tb_modulation_swapchain;

    localparam int IDX_W = 15;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [63:0]      SYS_TIME = '0;
    logic             UPDATE_SETTINGS = 1'b0;
    logic             REQ_SEGMENT = 1'b0;
    logic [7:0]       TRANSITION_MODE = '0;
    logic [63:0]      TRANSITION_VALUE = '0;
    logic [15:0]      REP = 16'hFFFF;
    logic [IDX_W-1:0] CYCLE_0 = 15'd9;
    logic [IDX_W-1:0] CYCLE_1 = 15'd7;
    logic [IDX_W-1:0] IDX_0_IN = '0;
    logic [IDX_W-1:0] IDX_1_IN = '0;
    logic             SEGMENT;
    logic [IDX_W-1:0] IDX_OUT;
    logic             STOP;
    logic             BUSY;

    int n_cmp = 0;
    int n_err = 0;

    modulation_swapchain #(.IDX_W(IDX_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .SYS_TIME(SYS_TIME),
        .UPDATE_SETTINGS(UPDATE_SETTINGS),
        .REQ_SEGMENT(REQ_SEGMENT),
        .TRANSITION_MODE(TRANSITION_MODE),
        .TRANSITION_VALUE(TRANSITION_VALUE),
        .REP(REP),
        .CYCLE_0(CYCLE_0),
        .CYCLE_1(CYCLE_1),
        .IDX_0_IN(IDX_0_IN),
        .IDX_1_IN(IDX_1_IN),
        .SEGMENT(SEGMENT),
        .IDX_OUT(IDX_OUT),
        .STOP(STOP),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic s,
                           input logic [IDX_W-1:0] i, input logic st,
                           input logic b);
        chk({tag, ".seg"}, 64'(SEGMENT), 64'(s));
        chk({tag, ".idx"}, 64'(IDX_OUT), 64'(i));
        chk({tag, ".stop"}, 64'(STOP), 64'(st));
        chk({tag, ".busy"}, 64'(BUSY), 64'(b));
    endtask

    task automatic upd(input logic s, input logic [7:0] m,
                       input logic [63:0] v, input logic [15:0] r);
        REQ_SEGMENT      = s;
        TRANSITION_MODE  = m;
        TRANSITION_VALUE = v;
        REP              = r;
        UPDATE_SETTINGS  = 1'b1;
        tick();
        UPDATE_SETTINGS  = 1'b0;
    endtask

    initial begin
        // reset
        #1 RST = 1'b1;
        #2;
        chk_all("reset", 1'b0, 15'd0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // seg0 free-run 0..9 repeating, infinite rep
        for (int i = 0; i < 20; i++) begin
            IDX_0_IN = 15'(i % 10);
            tick();
            chk("run0.idx", 64'(IDX_OUT), 64'(i % 10));
            chk("run0.seg", 64'(SEGMENT), 64'd0);
        end
        chk_all("run0.end", 1'b0, 15'd9, 1'b0, 1'b0);

        // immediate switch to seg1
        IDX_1_IN = 15'd5;
        upd(1'b1, 8'hFF, 64'd0, 16'hFFFF);
        chk_all("imm1", 1'b1, 15'd5, 1'b0, 1'b0);

        // back to seg0, then sync-index switch to seg1
        IDX_0_IN = 15'd2;
        upd(1'b0, 8'hFF, 64'd0, 16'hFFFF);
        chk_all("imm0", 1'b0, 15'd2, 1'b0, 1'b0);
        IDX_1_IN = 15'd3;
        tick();
        upd(1'b1, 8'h00, 64'd0, 16'hFFFF);
        chk_all("sync.latch", 1'b0, 15'd2, 1'b0, 1'b1);
        for (int i = 4; i <= 7; i++) begin
            IDX_1_IN = 15'(i);
            tick();
            chk_all("sync.wait", 1'b0, 15'd2, 1'b0, 1'b1);
        end
        IDX_1_IN = 15'd0;
        tick();
        chk_all("sync.commit", 1'b1, 15'd0, 1'b0, 1'b0);

        // system-time switch, future target
        upd(1'b0, 8'hFF, 64'd0, 16'hFFFF);
        chk_all("imm0b", 1'b0, 15'd2, 1'b0, 1'b0);
        SYS_TIME = 64'd990;
        upd(1'b1, 8'h01, 64'd1000, 16'hFFFF);
        chk_all("time.latch", 1'b0, 15'd2, 1'b0, 1'b1);
        for (int t = 991; t <= 999; t++) begin
            SYS_TIME = 64'(t);
            tick();
            chk("time.wait.seg", 64'(SEGMENT), 64'd0);
        end
        chk("time.wait.busy", 64'(BUSY), 64'd1);
        SYS_TIME = 64'd1000;
        tick();
        chk_all("time.commit", 1'b1, 15'd0, 1'b0, 1'b0);

        // system-time switch, past target
        upd(1'b0, 8'hFF, 64'd0, 16'hFFFF);
        SYS_TIME = 64'd990;
        upd(1'b1, 8'h01, 64'd500, 16'hFFFF);
        chk_all("past.latch", 1'b0, 15'd2, 1'b0, 1'b1);
        tick();
        chk_all("past.commit", 1'b1, 15'd0, 1'b0, 1'b0);

        // finite loop: REP=1 on seg1 with CYCLE_1=3 plays twice then stops
        upd(1'b0, 8'hFF, 64'd0, 16'hFFFF);
        CYCLE_1 = 15'd3;
        IDX_1_IN = 15'd0;
        upd(1'b1, 8'hFF, 64'd0, 16'd1);
        chk_all("loop.commit", 1'b1, 15'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            IDX_1_IN = 15'(i % 4);
            tick();
            chk_all("loop.play", 1'b1, 15'(i % 4), 1'b0, 1'b0);
        end
        IDX_1_IN = 15'd0;
        tick();
        chk_all("loop.stop", 1'b1, 15'd3, 1'b1, 1'b0);
        IDX_1_IN = 15'd1;
        tick();
        chk_all("loop.hold", 1'b1, 15'd3, 1'b1, 1'b0);
        IDX_1_IN = 15'd3;
        upd(1'b1, 8'hFF, 64'd0, 16'hFFFF);
        chk_all("loop.restart", 1'b1, 15'd3, 1'b0, 1'b0);
        IDX_1_IN = 15'd0;
        tick();
        chk_all("loop.replay", 1'b1, 15'd0, 1'b0, 1'b0);

        // pending sync request replaced by a same-segment request
        upd(1'b0, 8'hFF, 64'd0, 16'hFFFF);
        chk_all("cancel.seg0", 1'b0, 15'd2, 1'b0, 1'b0);
        upd(1'b1, 8'h00, 64'd0, 16'hFFFF);
        chk_all("cancel.pend", 1'b0, 15'd2, 1'b0, 1'b1);
        upd(1'b0, 8'hFF, 64'd0, 16'hFFFF);
        chk_all("cancel.clr", 1'b0, 15'd2, 1'b0, 1'b0);
        IDX_1_IN = 15'd5;
        tick();
        IDX_1_IN = 15'd0;
        tick();
        chk_all("cancel.wrap", 1'b0, 15'd2, 1'b0, 1'b0);

        // async reset while a sync request is pending
        upd(1'b1, 8'h00, 64'd0, 16'hFFFF);
        IDX_0_IN = 15'd4;
        tick();
        chk_all("rst.pre", 1'b0, 15'd4, 1'b0, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk_all("rst.async", 1'b0, 15'd0, 1'b0, 1'b0);
        #2 RST = 1'b0;
        IDX_1_IN = 15'd5;
        tick();
        IDX_1_IN = 15'd0;
        tick();
        chk_all("rst.lost", 1'b0, 15'd4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/modulation_swapchain.md
Name: modulation_swapchain

Overview:
- Consumer end of the modulation counter interface. Takes the two free-running per-segment sample indices produced by the modulation timer and selects which one drives the modulation BRAM read address.
- Manages segment switching (immediate, index-synchronous or system-time-triggered) and finite loop counting with a stop state.
- Sits between the modulation timer and the modulation memory reader.

Parameters:
- IDX_W, 15, width of sample indices and cycle registers.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- SYS_TIME  in  64  global system time
- UPDATE_SETTINGS  in  1  one-cycle pulse; latches the request fields below
- REQ_SEGMENT  in  1  requested segment
- TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0xFF IMMEDIATE
- TRANSITION_VALUE  in  64  target SYS_TIME for SYS_TIME mode
- REP  in  16  loop count for requested segment; 0xFFFF = infinite, else REP+1 plays
- CYCLE_0, CYCLE_1  in  IDX_W  last valid index of each segment
- IDX_0_IN, IDX_1_IN  in  IDX_W  timer indices for segments 0 and 1
- SEGMENT  out  1  active segment
- IDX_OUT  out  IDX_W  read index for active segment
- STOP  out  1  finite playback complete
- BUSY  out  1  transition pending

Behaviour:
- Reset values: SEGMENT=0, IDX_OUT=0, STOP=0, BUSY=0, state RUN, active rep=0xFFFF, loop count=0, prev indices=0.
- Wrap detect for segment s, in every cycle: wrap_s = IDX_s_IN < prev_s. prev_s is IDX_s_IN registered. A CYCLE of 0 never wraps, so a finite REP with CYCLE=0 never stops (documented; software forbids this combination).
- States: RUN, WAIT_IDX, WAIT_TIME, STOPPED.
- IDX_OUT is registered with 1-cycle latency. In RUN/WAIT_*: IDX_OUT <= IDX_<active>_IN. In STOPPED: IDX_OUT holds CYCLE_<active>.
- UPDATE_SETTINGS in any state latches REQ_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE and REP into pending registers.
  - REQ_SEGMENT == SEGMENT: no transition. Active rep <= REP, loop count <= 0, STOP <= 0, state <= RUN, BUSY <= 0, effective next edge. Any pending transition is cancelled.
  - IMMEDIATE: commit on the next edge.
  - SYNC_IDX: state WAIT_IDX, BUSY=1.
  - SYS_TIME: state WAIT_TIME, BUSY=1.
  - Any other mode value: request dropped, state unchanged.
  - A new UPDATE_SETTINGS while BUSY replaces the pending request; only the latest one commits.
- Commit conditions:
  - WAIT_IDX commits on the first cycle where wrap_<requested> = 1.
  - WAIT_TIME commits on the first cycle where SYS_TIME >= TRANSITION_VALUE (unsigned). A past time commits on the first cycle after latch.
- Commit edge: SEGMENT <= req, IDX_OUT <= IDX_<req>_IN, active rep <= pending REP, loop count <= 0, STOP <= 0, BUSY <= 0, state RUN.
- Commits are allowed from STOPPED; while waiting, the active segment keeps its own loop/stop behaviour.
- Loop counting (RUN, active rep != 0xFFFF):
  - On wrap_<active>: if loop count == rep, go to STOPPED with STOP=1 and IDX_OUT=CYCLE_<active> on that same edge.
  - Otherwise loop count +1.
  - The commit cycle itself never counts as a wrap.
- Simultaneous UPDATE_SETTINGS and commit condition in one cycle: the new request wins; the old pending request is discarded.
- Asynchronous RST mid-transition: all state returns to reset values immediately; any pending request is lost.

Test Plan:
- Reset, then run IDX_0_IN 0..9 repeating with CYCLE_0=9 → SEGMENT=0, IDX_OUT follows IDX_0_IN delayed 1 cycle, STOP=0, BUSY=0.
- IMMEDIATE to seg1 with REP=0xFFFF while IDX_1_IN=5 → next edge SEGMENT=1, IDX_OUT=5, BUSY stays 0.
- SYNC_IDX to seg1 while IDX_1_IN counts 3..7 then wraps 7→0 (CYCLE_1=7) → BUSY=1 until the wrap; on that edge SEGMENT=1 and IDX_OUT=0.
- SYS_TIME mode with TRANSITION_VALUE=1000 at SYS_TIME=990 → SEGMENT flips on the edge where SYS_TIME=1000 is sampled. Repeat with TRANSITION_VALUE=500 at SYS_TIME=990 → commits the next cycle.
- IMMEDIATE to seg1 with REP=1, CYCLE_1=3 → two full plays 0..3, then STOP=1 at the second wrap and IDX_OUT held at 3. A following same-segment UPDATE_SETTINGS clears STOP and playback restarts.
- SYNC_IDX request pending, second request (IMMEDIATE to seg0) issued before the wrap, then RST asserted mid-wait in a separate run → first case: SEGMENT stays 0 and BUSY clears. Second case: all outputs return to 0 asynchronously.
